draw_engine: RTL and testbench
==============================

Name: draw_engine

Overview:
Pixel-rasterising datapath that services the game controller's 5-bit draw command (ld_draw) and drives the VGA adapter's pixel-write port. Each accepted command selects a filled rectangle: a brick, the paddle or the ball, drawn in its own colour or erased in black. The engine sweeps the rectangle one pixel per clock and holds busy high until the last pixel is written. The controller's per-command busy inputs (brick populate, paddle/ball erase/draw, brick remove) are all driven from busy at top level.

Parameters:
BRICK_W, 32, brick width in pixels
BRICK_H, 8, brick height in pixels
BRICK_X0, 16, x of brick 1 left edge
BRICK_Y0, 8, y of brick 1 top edge
BRICK_GAP, 4, gap between bricks, both axes
PADDLE_W, 24, paddle width
PADDLE_H, 4, paddle height
PADDLE_Y, 112, paddle top row (fixed)
BALL_SZ, 2, ball is BALL_SZ x BALL_SZ square

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
cmd  in  5  draw command (ld_draw encoding)
paddle_x  in  8  current paddle left x
ball_x  in  8  current ball left x
ball_y  in  7  current ball top y
busy  out  1  command in progress (combinational)
plot  out  1  pixel write strobe to VGA adapter
x  out  8  pixel x
y  out  7  pixel y
colour  out  3  pixel colour

Behaviour:
- Command codes: 0 idle; 1-12 draw brick N; 13 erase paddle; 14 draw paddle; 15 erase ball; 16 draw ball; 17-28 erase brick N = cmd-16; 29-31 invalid, ignored like 0.
- Brick N geometry: col=(N-1)%4, row=(N-1)/4; left = BRICK_X0 + col*(BRICK_W+BRICK_GAP); top = BRICK_Y0 + row*(BRICK_H+BRICK_GAP); size BRICK_W x BRICK_H.
- Colours: brick row0 3'b100, row1 3'b110, row2 3'b010; paddle 3'b011; ball 3'b111; every erase 3'b000.
- Position history: old_paddle_x is captured on acceptance of cmd 14. old_ball_x and old_ball_y are captured on acceptance of cmd 16.
- Cmd 13 draws at old_paddle_x / PADDLE_Y. Cmd 15 draws at old_ball_x / old_ball_y. Cmd 14 and 16 use live inputs sampled at acceptance.
- Input changes during DRAW are ignored.
- FSM states:
  - IDLE: no command accepted.
  - DRAW: sweeping a rectangle.
  - DONE: command finished; waiting for cmd to change.
- last_cmd register holds the most recently accepted code.
- new_cmd = valid(cmd) && !(state==DONE && cmd==last_cmd).
- Transitions:
  - IDLE or DONE with new_cmd: go to DRAW. Latch base_x, base_y, width, height, colour and last_cmd; clear cx and cy.
  - DONE with cmd==last_cmd: stay in DONE.
  - DONE with cmd invalid or 0: go to IDLE.
  - DRAW: go to DONE after the last pixel.
- Controller cycle ordering: when busy drops, the controller changes cmd on the next edge. DONE therefore prevents re-triggering the same code, and a different code is accepted directly from DONE with no idle gap.
- busy = (state==DRAW) || new_cmd. Busy is high in the acceptance cycle, so the controller never skips a command.
- Sweep order is row-major: cx runs 0..width-1 (inner), cy runs 0..height-1 (outer). One pixel per clock.
- While in DRAW: plot=1, x=base_x+cx (mod 256), y=base_y+cy (mod 128), colour=latched colour. No clipping; off-screen pixels are the adapter's problem.
- Timing: accept at edge k; plot is high for exactly W*H cycles starting k+1. On the final pixel (cx==width-1 and cy==height-1), state becomes DONE at the next edge, and busy is low from then on.
- Outside DRAW: plot=0, x=0, y=0, colour=0.
- Reset values (resetn low at a clock edge, including mid-DRAW): state IDLE, cx=cy=0, last_cmd=0, old_paddle_x=0, old_ball_x=0, old_ball_y=0, plot=0, x=0, y=0, colour=0. Sweep is abandoned with no further plot pulses.

Test Plan:
- cmd=1 held until busy falls -> 256 plot pulses; first pixel (16,8) colour 100, last (47,15); busy high 257 cycles, then low with no retrigger while cmd stays 1.
- cmd=6 -> rectangle from (52,20) to (83,27), colour 110; then cmd=22 -> same rectangle in colour 000.
- paddle_x=60, cmd=14 -> 96 pixels at (60..83, 112..115) colour 011; set paddle_x=70, cmd=13 -> erase covers (60..83, 112..115), not 70.
- ball (100,50), cmd=16 -> 4 pixels (100,50),(101,50),(100,51),(101,51) colour 111; then cmd=15 after ball moves to (102,52) -> erase at (100,50).
- Back-to-back: cmd 1 busy drops, cmd switches to 2 the next cycle -> busy high in that same cycle and brick 2 starts at (52,8) with no idle gap; cmd=30 -> busy=0, plot=0.
- Assert resetn low mid-sweep of cmd=14 -> plot=0 next cycle, state IDLE; after release with cmd=13 -> erase drawn at x=0.

Source files
------------

// File: rtl/draw_engine.sv
`default_nettype none
// ============================================================================
// Module   : draw_engine
// Purpose  : Rasterises brick/paddle/ball rectangles one pixel per clock
//            for the VGA adapter's pixel-write port.
// Revision : 1.0 - initial release
// ============================================================================
module draw_engine #(
   parameter int BRICK_W   = 32,
   parameter int BRICK_H   = 8,
   parameter int BRICK_X0  = 16,
   parameter int BRICK_Y0  = 8,
   parameter int BRICK_GAP = 4,
   parameter int PADDLE_W  = 24,
   parameter int PADDLE_H  = 4,
   parameter int PADDLE_Y  = 112,
   parameter int BALL_SZ   = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [4:0] cmd,
   input  logic [7:0] paddle_x,
   input  logic [7:0] ball_x,
   input  logic [6:0] ball_y,
   output logic       busy,
   output logic       plot,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   logic [4:0] r_last_cmd;
   logic [7:0] r_old_paddle_x;
   logic [7:0] r_old_ball_x;
   logic [6:0] r_old_ball_y;
   logic [7:0] r_cx, r_cy, r_w, r_h, r_bx;
   logic       r_plot;
   logic [7:0] r_x;
   logic [6:0] r_y;
   logic [2:0] r_colour;

   logic       w_valid, w_new_cmd;
   logic [3:0] w_idx;
   logic [7:0] w_bx, w_w, w_h;
   logic [6:0] w_by;
   logic [2:0] w_colour;

   assign w_valid   = (cmd != 5'd0) && (cmd <= 5'd28);
   assign w_new_cmd = w_valid && !((r_state == S_DONE) && (cmd == r_last_cmd));
   assign busy      = (r_state == S_DRAW) || w_new_cmd;

   always_comb begin
      w_idx    = 4'd0;
      w_bx     = 8'd0;
      w_by     = 7'd0;
      w_w      = 8'd0;
      w_h      = 8'd0;
      w_colour = 3'b000;
      if (cmd >= 5'd1 && cmd <= 5'd12)
         w_idx = 4'(cmd - 5'd1);
      else if (cmd >= 5'd17 && cmd <= 5'd28)
         w_idx = 4'(cmd - 5'd17);

      if (cmd == 5'd13 || cmd == 5'd14) begin
         w_bx     = (cmd == 5'd13) ? r_old_paddle_x : paddle_x;
         w_by     = 7'(PADDLE_Y);
         w_w      = 8'(PADDLE_W);
         w_h      = 8'(PADDLE_H);
         w_colour = (cmd == 5'd14) ? 3'b011 : 3'b000;
      end else if (cmd == 5'd15 || cmd == 5'd16) begin
         w_bx     = (cmd == 5'd15) ? r_old_ball_x : ball_x;
         w_by     = (cmd == 5'd15) ? r_old_ball_y : ball_y;
         w_w      = 8'(BALL_SZ);
         w_h      = 8'(BALL_SZ);
         w_colour = (cmd == 5'd16) ? 3'b111 : 3'b000;
      end else begin
         // Bricks tile a 4-wide grid: low index bits pick column, high bits row.
         w_bx = 8'(BRICK_X0 + int'(w_idx[1:0]) * (BRICK_W + BRICK_GAP));
         w_by = 7'(BRICK_Y0 + int'(w_idx[3:2]) * (BRICK_H + BRICK_GAP));
         w_w  = 8'(BRICK_W);
         w_h  = 8'(BRICK_H);
         if (cmd <= 5'd12) begin
            case (w_idx[3:2])
               2'd0:    w_colour = 3'b100;
               2'd1:    w_colour = 3'b110;
               default: w_colour = 3'b010;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state        <= S_IDLE;
         r_last_cmd     <= 5'd0;
         r_old_paddle_x <= 8'd0;
         r_old_ball_x   <= 8'd0;
         r_old_ball_y   <= 7'd0;
         r_cx           <= 8'd0;
         r_cy           <= 8'd0;
         r_w            <= 8'd0;
         r_h            <= 8'd0;
         r_bx           <= 8'd0;
         r_plot         <= 1'b0;
         r_x            <= 8'd0;
         r_y            <= 7'd0;
         r_colour       <= 3'b000;
      end else begin
         case (r_state)
            S_DRAW: begin
               if (r_cx == r_w - 8'd1) begin
                  r_cx <= 8'd0;
                  if (r_cy == r_h - 8'd1) begin
                     r_state  <= S_DONE;
                     r_cy     <= 8'd0;
                     r_plot   <= 1'b0;
                     r_x      <= 8'd0;
                     r_y      <= 7'd0;
                     r_colour <= 3'b000;
                  end else begin
                     r_cy <= r_cy + 8'd1;
                     r_x  <= r_bx;
                     r_y  <= r_y + 7'd1;
                  end
               end else begin
                  r_cx <= r_cx + 8'd1;
                  r_x  <= r_x + 8'd1;
               end
            end
            default: begin
               if (w_new_cmd) begin
                  r_state    <= S_DRAW;
                  r_last_cmd <= cmd;
                  r_cx       <= 8'd0;
                  r_cy       <= 8'd0;
                  r_w        <= w_w;
                  r_h        <= w_h;
                  r_bx       <= w_bx;
                  r_plot     <= 1'b1;
                  r_x        <= w_bx;
                  r_y        <= w_by;
                  r_colour   <= w_colour;
                  if (cmd == 5'd14)
                     r_old_paddle_x <= paddle_x;
                  if (cmd == 5'd16) begin
                     r_old_ball_x <= ball_x;
                     r_old_ball_y <= ball_y;
                  end
               end else if (r_state == S_DONE && cmd != r_last_cmd) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign plot   = r_plot;
   assign x      = r_x;
   assign y      = r_y;
   assign colour = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_draw_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_engine
// Purpose  : Self-checking bench for draw_engine against a rectangle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_engine;

   logic       clk = 1'b0;
   logic       resetn;
   logic [4:0] cmd;
   logic [7:0] paddle_x, ball_x;
   logic [6:0] ball_y;
   logic       busy, plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int m_old_px, m_old_bx, m_old_by, m_last;
   bit m_done;

   draw_engine dut (
      .clk(clk), .resetn(resetn), .cmd(cmd), .paddle_x(paddle_x),
      .ball_x(ball_x), .ball_y(ball_y), .busy(busy), .plot(plot),
      .x(x), .y(y), .colour(colour)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_old_px = 0; m_old_bx = 0; m_old_by = 0; m_last = 0; m_done = 0;
   endtask

   // Presents cmd at the edge after the previous busy-low cycle, then checks
   // the acceptance cycle, every pixel, and the following idle cycle.
   task automatic do_cmd(input int c);
      int bx, by, w, h, col, n, row;
      bit valid, nw;
      bx = 0; by = 0; w = 0; h = 0; col = 0;
      @(posedge clk); #1;
      cmd = 5'(c);
      valid = (c >= 1 && c <= 28);
      nw = valid && !(m_done && c == m_last);
      if (nw) begin
         if (c == 13) begin
            bx = m_old_px; by = 112; w = 24; h = 4; col = 0;
         end else if (c == 14) begin
            bx = paddle_x; by = 112; w = 24; h = 4; col = 3;
            m_old_px = paddle_x;
         end else if (c == 15) begin
            bx = m_old_bx; by = m_old_by; w = 2; h = 2; col = 0;
         end else if (c == 16) begin
            bx = ball_x; by = ball_y; w = 2; h = 2; col = 7;
            m_old_bx = ball_x; m_old_by = ball_y;
         end else begin
            n = (c <= 12) ? c : c - 16;
            row = (n - 1) / 4;
            bx = 16 + ((n - 1) % 4) * 36;
            by = 8 + row * 12;
            w = 32; h = 8;
            col = (c > 12) ? 0 : (row == 0) ? 4 : (row == 1) ? 6 : 2;
         end
         m_last = c;
      end
      @(negedge clk);
      vectors++;
      if (busy !== nw || plot !== 1'b0) begin
         miscompares++;
         $display("FAIL accept cmd=%0d: busy=%b plot=%b, expected busy=%b plot=0",
                  c, busy, plot, nw);
      end
      if (nw) begin
         for (int i = 0; i < h; i++) begin
            for (int j = 0; j < w; j++) begin
               @(posedge clk); #1;
               paddle_x = 8'($urandom);
               ball_x = 8'($urandom);
               ball_y = 7'($urandom);
               @(negedge clk);
               vectors++;
               if (plot !== 1'b1 || busy !== 1'b1 || x !== 8'((bx + j) % 256) ||
                   y !== 7'((by + i) % 128) || colour !== 3'(col)) begin
                  miscompares++;
                  $display("FAIL pixel cmd=%0d (%0d,%0d): plot=%b busy=%b x=%0d y=%0d c=%0d, expected 1 1 %0d %0d %0d",
                           c, j, i, plot, busy, x, y, colour,
                           (bx + j) % 256, (by + i) % 128, col);
               end
            end
         end
         m_done = 1;
      end else if (!valid) begin
         m_done = 0;
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || plot !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
         miscompares++;
         $display("FAIL after cmd=%0d: busy=%b plot=%b x=%0d y=%0d c=%0d, expected all 0",
                  c, busy, plot, x, y, colour);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; cmd = 5'd0; paddle_x = 8'd0; ball_x = 8'd0; ball_y = 7'd0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || plot !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
         miscompares++;
         $display("FAIL reset: busy=%b plot=%b x=%0d y=%0d c=%0d, expected all 0",
                  busy, plot, x, y, colour);
      end
      resetn = 1'b1;
   endtask

   task automatic test_bricks();
      do_cmd(1);
      do_cmd(1);
      do_cmd(0);
      do_cmd(6);
      do_cmd(22);
      do_cmd(12);
   endtask

   task automatic test_paddle();
      paddle_x = 8'd60;
      do_cmd(14);
      paddle_x = 8'd70;
      do_cmd(13);
   endtask

   task automatic test_ball();
      ball_x = 8'd100; ball_y = 7'd50;
      do_cmd(16);
      ball_x = 8'd102; ball_y = 7'd52;
      do_cmd(15);
   endtask

   task automatic test_back_to_back();
      do_cmd(1);
      do_cmd(2);
      do_cmd(30);
      do_cmd(31);
   endtask

   task automatic test_mid_reset();
      @(posedge clk); #1;
      paddle_x = 8'd90;
      cmd = 5'd14;
      repeat (10) @(posedge clk);
      #1;
      resetn = 1'b0;
      cmd = 5'd0;
      @(posedge clk); #1;
      resetn = 1'b1;
      model_reset();
      @(negedge clk);
      vectors++;
      if (plot !== 1'b0 || busy !== 1'b0 || x !== 8'd0) begin
         miscompares++;
         $display("FAIL mid_reset: plot=%b busy=%b x=%0d, expected 0 0 0", plot, busy, x);
      end
      paddle_x = 8'd200;
      do_cmd(13);
   endtask

   task automatic test_random();
      int c;
      for (int k = 0; k < 40; k++) begin
         paddle_x = 8'($urandom);
         ball_x = 8'($urandom);
         ball_y = 7'($urandom);
         c = (($urandom % 4) == 0) ? m_last : int'($urandom_range(0, 31));
         do_cmd(c);
      end
   endtask

   initial begin
      test_reset();
      test_bricks();
      test_paddle();
      test_ball();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
